// File: rtl/fifo_rptr_empty_ctrl_pkg.sv
// Shared definitions for the Gray-pointer FIFO pointer controllers.
// Both the read-side empty controller and the write-side full controller use them.
package fifo_rptr_empty_ctrl_pkg;

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int ptr_width(input int addrsize);
        return addrsize + 1;
    endfunction

    function automatic int fifo_depth(input int addrsize);
        return 1 << addrsize;
    endfunction

endpackage

// File: rtl/fifo_rptr_empty_ctrl_gray2bin.sv
// Combinational Gray-to-binary conversion (XOR prefix from the MSB down).
// Also used by the write-side controller for the synchronised read pointer.
module fifo_rptr_empty_ctrl_gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    assign bin_o[WIDTH-1] = gray_i[WIDTH-1];

    generate
        for (genvar gi = WIDTH - 2; gi >= 0; gi--) begin : g_prefix
            assign bin_o[gi] = bin_o[gi+1] ^ gray_i[gi];
        end
    endgenerate

endmodule

// File: rtl/fifo_rptr_empty_ctrl.sv
// Read-domain pointer/status controller: binary and Gray read pointers, RAM read
// address, empty / almost-empty flags, fill level and sticky underflow.
module fifo_rptr_empty_ctrl
    import fifo_rptr_empty_ctrl_pkg::*;
#(
    parameter int ADDRSIZE  = 4,
    parameter int AE_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic                clr_underflow,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                ralmost_empty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                runderflow
);

    localparam int PW = ptr_width(ADDRSIZE);

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rgray_q, rgray_d;
    logic [PW-1:0] rlevel_q, rlevel_d;
    logic [PW-1:0] wbin;
    logic          rempty_q, rempty_d;
    logic          ralmost_empty_q, ralmost_empty_d;
    logic          runderflow_q, runderflow_d;
    logic          pop;

    fifo_rptr_empty_ctrl_gray2bin #(
        .WIDTH (PW)
    ) u_wptr_g2b (
        .gray_i (rq2_wptr),
        .bin_o  (wbin)
    );

    assign pop             = rinc & ~rempty_q;
    assign rbin_d          = rbin_q + PW'(pop);
    assign rgray_d         = (rbin_d >> 1) ^ rbin_d;
    // Level uses the post-pop pointer so a pop and a new write pointer combine in one step.
    assign rlevel_d        = wbin - rbin_d;
    assign rempty_d        = (rgray_d == rq2_wptr);
    assign ralmost_empty_d = (rlevel_d <= PW'(AE_THRESH));

    always_comb begin
        runderflow_d = runderflow_q;
        if (rinc && rempty_q) begin
            runderflow_d = 1'b1;
        end else if (clr_underflow) begin
            runderflow_d = 1'b0;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q          <= '0;
            rgray_q         <= '0;
            rlevel_q        <= '0;
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b1;
            runderflow_q    <= 1'b0;
        end else begin
            rbin_q          <= rbin_d;
            rgray_q         <= rgray_d;
            rlevel_q        <= rlevel_d;
            rempty_q        <= rempty_d;
            ralmost_empty_q <= ralmost_empty_d;
            runderflow_q    <= runderflow_d;
        end
    end

    // Address comes from the registered pointer so the head word is readable while rempty=0.
    assign raddr         = rbin_q[ADDRSIZE-1:0];
    assign rptr          = rgray_q;
    assign rempty        = rempty_q;
    assign ralmost_empty = ralmost_empty_q;
    assign rlevel        = rlevel_q;
    assign runderflow    = runderflow_q;

endmodule
